// File: rtl/pipe_controller_if.sv
// Decode-to-pipeline control bundle between the RV32I datapath/hazard unit and pipe_controller.
// The master is the datapath side; the slave is the control unit.
interface pipe_controller_if #(
  parameter int ALUCTRL_W = 4
);
  logic [6:0]           opD;
  logic [2:0]           funct3D;
  logic [6:0]           funct7D;
  logic                 FlushE;
  logic                 ZeroE;
  logic                 LtE;
  logic                 LtuE;
  logic [2:0]           ImmSrcD;
  logic                 AluSrcAE;
  logic                 AluSrcBE;
  logic [ALUCTRL_W-1:0] AluControlE;
  logic                 PCSrcE;
  logic                 TargetSrcE;
  logic                 MemWriteM;
  logic [1:0]           ResultSrcW;
  logic                 RegWriteE;
  logic                 RegWriteM;
  logic                 RegWriteW;
  logic                 ResultSrcE0;
  logic                 IllegalE;

  modport master (
    output opD, funct3D, funct7D, FlushE, ZeroE, LtE, LtuE,
    input  ImmSrcD, AluSrcAE, AluSrcBE, AluControlE, PCSrcE, TargetSrcE, MemWriteM,
           ResultSrcW, RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, IllegalE
  );

  modport slave (
    input  opD, funct3D, funct7D, FlushE, ZeroE, LtE, LtuE,
    output ImmSrcD, AluSrcAE, AluSrcBE, AluControlE, PCSrcE, TargetSrcE, MemWriteM,
           ResultSrcW, RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, IllegalE
  );
endinterface

// File: rtl/pipe_controller.sv
// RV32I control unit for the 5-stage pipeline: combinational decode in D, control carried
// through ID/EX, EX/MEM and MEM/WB registers, branch/jump redirect resolved in E.
module pipe_controller #(
  parameter int ALUCTRL_W = 4,
  parameter int EN_MUL    = 0
) (
  input logic             clk,
  input logic             reset,
  pipe_controller_if.slave bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(7);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(9);
  localparam logic [ALUCTRL_W-1:0] ALU_MUL  = ALUCTRL_W'(10);

  typedef struct packed {
    logic                 reg_write;
    logic [1:0]           result_src;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 alu_src_a;
    logic                 alu_src_b;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic                 target_src;
    logic                 illegal;
  } ctrl_t;

  ctrl_t      ctrl_d;
  ctrl_t      ctrl_e;
  logic [2:0] imm_src_d;
  logic [2:0] funct3_e;
  logic       bad;
  logic       cond_e;
  logic       reg_write_m;
  logic [1:0] result_src_m;
  logic       mem_write_m;
  logic       reg_write_w;
  logic [1:0] result_src_w;

  function automatic logic [ALUCTRL_W-1:0] alu_of(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    ctrl_d    = '0;
    imm_src_d = 3'b000;
    bad       = 1'b0;
    case (bus.opD)
      OP_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b01;
        ctrl_d.alu_src_b  = 1'b1;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src_b = 1'b1;
        imm_src_d        = 3'b001;
      end
      OP_R: begin
        ctrl_d.reg_write = 1'b1;
        case (bus.funct7D)
          7'b0000000: ctrl_d.alu_ctrl = alu_of(bus.funct3D);
          7'b0100000: begin
            if (bus.funct3D == 3'b000)      ctrl_d.alu_ctrl = ALU_SUB;
            else if (bus.funct3D == 3'b101) ctrl_d.alu_ctrl = ALU_SRA;
            else                            bad = 1'b1;
          end
          7'b0000001: begin
            if (EN_MUL != 0 && bus.funct3D == 3'b000) ctrl_d.alu_ctrl = ALU_MUL;
            else                                      bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      OP_I: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src_b = 1'b1;
        ctrl_d.alu_ctrl  = alu_of(bus.funct3D);
        // Shift-immediates reuse funct7 as an opcode extension; other I-ops treat it as imm.
        if (bus.funct3D == 3'b001 && bus.funct7D != 7'b0000000) bad = 1'b1;
        if (bus.funct3D == 3'b101) begin
          if (bus.funct7D == 7'b0100000)      ctrl_d.alu_ctrl = ALU_SRA;
          else if (bus.funct7D != 7'b0000000) bad = 1'b1;
        end
      end
      OP_BRANCH: begin
        ctrl_d.branch   = 1'b1;
        ctrl_d.alu_ctrl = ALU_SUB;
        imm_src_d       = 3'b010;
        if (bus.funct3D[2:1] == 2'b01) bad = 1'b1;
      end
      OP_JAL: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b10;
        imm_src_d         = 3'b011;
      end
      OP_JALR: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b10;
        ctrl_d.alu_src_b  = 1'b1;
        ctrl_d.target_src = 1'b1;
        if (bus.funct3D != 3'b000) bad = 1'b1;
      end
      OP_LUI: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b11;
        imm_src_d         = 3'b100;
      end
      OP_AUIPC: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 1'b1;
        imm_src_d        = 3'b100;
      end
      default: bad = 1'b1;
    endcase
    // An illegal instruction must not write, store or redirect anything downstream.
    if (bad) begin
      ctrl_d         = '0;
      ctrl_d.illegal = 1'b1;
      imm_src_d      = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_e       <= '0;
      funct3_e     <= 3'b000;
      reg_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      mem_write_m  <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
    end else begin
      if (bus.FlushE) begin
        ctrl_e   <= '0;
        funct3_e <= 3'b000;
      end else begin
        ctrl_e   <= ctrl_d;
        funct3_e <= bus.funct3D;
      end
      reg_write_m  <= ctrl_e.reg_write;
      result_src_m <= ctrl_e.result_src;
      mem_write_m  <= ctrl_e.mem_write;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
    end
  end

  always_comb begin
    case (funct3_e)
      3'b000:  cond_e = bus.ZeroE;
      3'b001:  cond_e = ~bus.ZeroE;
      3'b100:  cond_e = bus.LtE;
      3'b101:  cond_e = ~bus.LtE;
      3'b110:  cond_e = bus.LtuE;
      3'b111:  cond_e = ~bus.LtuE;
      default: cond_e = 1'b0;
    endcase
  end

  assign bus.ImmSrcD     = imm_src_d;
  assign bus.AluSrcAE    = ctrl_e.alu_src_a;
  assign bus.AluSrcBE    = ctrl_e.alu_src_b;
  assign bus.AluControlE = ctrl_e.alu_ctrl;
  assign bus.PCSrcE      = ctrl_e.jump | (ctrl_e.branch & cond_e);
  assign bus.TargetSrcE  = ctrl_e.target_src;
  assign bus.MemWriteM   = mem_write_m;
  assign bus.ResultSrcW  = result_src_w;
  assign bus.RegWriteE   = ctrl_e.reg_write;
  assign bus.RegWriteM   = reg_write_m;
  assign bus.RegWriteW   = reg_write_w;
  assign bus.ResultSrcE0 = ctrl_e.result_src[0];
  assign bus.IllegalE    = ctrl_e.illegal;

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: directed scenarios plus a randomized run against
// a mnemonic-level pipeline model, on two instances (multiply disabled and enabled).
module tb_pipe_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0;
  logic [2:0] f3 = 3'b0;
  logic [6:0] f7 = 7'b0;
  logic       flush = 1'b0;
  logic       zero = 1'b0;
  logic       lt = 1'b0;
  logic       ltu = 1'b0;

  int passed = 0;
  int total  = 0;

  pipe_controller_if #(.ALUCTRL_W(4)) if0 ();
  pipe_controller_if #(.ALUCTRL_W(4)) if1 ();

  assign if0.opD = op;    assign if1.opD = op;
  assign if0.funct3D = f3; assign if1.funct3D = f3;
  assign if0.funct7D = f7; assign if1.funct7D = f7;
  assign if0.FlushE = flush; assign if1.FlushE = flush;
  assign if0.ZeroE = zero; assign if1.ZeroE = zero;
  assign if0.LtE = lt;     assign if1.LtE = lt;
  assign if0.LtuE = ltu;   assign if1.LtuE = ltu;

  pipe_controller #(.ALUCTRL_W(4), .EN_MUL(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  pipe_controller #(.ALUCTRL_W(4), .EN_MUL(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       a;
    logic       b;
    logic [3:0] alu;
    logic       tgt;
    logic       ill;
    logic [2:0] imm;
  } ctrl_t;

  // The model tracks which instruction occupies each stage by name; "nop" is a bubble.
  string e0 = "nop", m0 = "nop", w0 = "nop";
  string e1 = "nop", m1 = "nop", w1 = "nop";

  function automatic string mnemonic(input logic [6:0] o, input logic [2:0] fn3,
                                     input logic [6:0] fn7, input bit en_mul);
    string rnames[8];
    string inames[8];
    string bnames[8];
    rnames = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
    inames = '{"addi", "slli", "slti", "sltiu", "xori", "srli", "ori", "andi"};
    bnames = '{"beq", "bne", "illegal", "illegal", "blt", "bge", "bltu", "bgeu"};
    case (o)
      7'b0000011: return "lw";
      7'b0100011: return "sw";
      7'b0110011: begin
        if (fn7 == 7'b0000001) return (en_mul && fn3 == 3'd0) ? "mul" : "illegal";
        if (fn7 == 7'b0100000) return (fn3 == 3'd0) ? "sub" : (fn3 == 3'd5) ? "sra" : "illegal";
        if (fn7 != 7'b0000000) return "illegal";
        return rnames[fn3];
      end
      7'b0010011: begin
        if (fn3 == 3'd1 && fn7 != 7'b0000000) return "illegal";
        if (fn3 == 3'd5 && fn7 == 7'b0100000) return "srai";
        if (fn3 == 3'd5 && fn7 != 7'b0000000) return "illegal";
        return inames[fn3];
      end
      7'b1100011: return bnames[fn3];
      7'b1101111: return "jal";
      7'b1100111: return (fn3 == 3'd0) ? "jalr" : "illegal";
      7'b0110111: return "lui";
      7'b0010111: return "auipc";
      default:    return "illegal";
    endcase
  endfunction

  function automatic ctrl_t controls_of(input string m);
    ctrl_t c;
    c = '0;
    case (m)
      "sub", "beq", "bne", "blt", "bge", "bltu", "bgeu": c.alu = 4'd1;
      "and", "andi":  c.alu = 4'd2;
      "or", "ori":    c.alu = 4'd3;
      "xor", "xori":  c.alu = 4'd4;
      "slt", "slti":  c.alu = 4'd5;
      "sltu", "sltiu": c.alu = 4'd6;
      "sll", "slli":  c.alu = 4'd7;
      "srl", "srli":  c.alu = 4'd8;
      "sra", "srai":  c.alu = 4'd9;
      "mul":          c.alu = 4'd10;
      default:        c.alu = 4'd0;
    endcase
    case (m)
      "nop", "illegal", "sw", "beq", "bne", "blt", "bge", "bltu", "bgeu": c.rw = 1'b0;
      default: c.rw = 1'b1;
    endcase
    case (m)
      "lw":          c.rs = 2'b01;
      "jal", "jalr": c.rs = 2'b10;
      "lui":         c.rs = 2'b11;
      default:       c.rs = 2'b00;
    endcase
    case (m)
      "lw", "sw", "jalr", "auipc", "addi", "slti", "sltiu", "xori", "ori", "andi",
      "slli", "srli", "srai": c.b = 1'b1;
      default: c.b = 1'b0;
    endcase
    case (m)
      "sw":                                       c.imm = 3'b001;
      "beq", "bne", "blt", "bge", "bltu", "bgeu": c.imm = 3'b010;
      "jal":                                      c.imm = 3'b011;
      "lui", "auipc":                             c.imm = 3'b100;
      default:                                    c.imm = 3'b000;
    endcase
    c.mw  = (m == "sw");
    c.a   = (m == "auipc");
    c.tgt = (m == "jalr");
    c.ill = (m == "illegal");
    if (c.ill) c.alu = 4'd0;
    return c;
  endfunction

  function automatic logic redirect(input string m);
    case (m)
      "jal", "jalr": return 1'b1;
      "beq":  return zero;
      "bne":  return !zero;
      "blt":  return lt;
      "bge":  return !lt;
      "bltu": return ltu;
      "bgeu": return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_instr(input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7);
    op = o;
    f3 = fn3;
    f7 = fn7;
  endtask

  task automatic tick();
    if (reset) begin
      e0 = "nop"; m0 = "nop"; w0 = "nop";
      e1 = "nop"; m1 = "nop"; w1 = "nop";
    end else begin
      w0 = m0; m0 = e0; e0 = flush ? "nop" : mnemonic(op, f3, f7, 1'b0);
      w1 = m1; m1 = e1; e1 = flush ? "nop" : mnemonic(op, f3, f7, 1'b1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_instr(7'b0110011, 3'b000, 7'b0100000);
    tick();
    reset = 1'b0;
    #1;
    total++; if ({if0.AluControlE, if0.RegWriteE, if0.PCSrcE, if0.IllegalE} !== 7'd0)
      $display("[TB] FAIL reset_e_outputs: got %b want 0", {if0.AluControlE, if0.RegWriteE, if0.PCSrcE, if0.IllegalE}); else passed++;
    total++; if ({if0.ResultSrcW, if0.RegWriteW, if0.RegWriteM, if0.MemWriteM} !== 5'd0)
      $display("[TB] FAIL reset_mw_outputs: got %b want 0", {if0.ResultSrcW, if0.RegWriteW, if0.RegWriteM, if0.MemWriteM}); else passed++;
    tick();
    total++; if (if0.AluControlE !== 4'd1) $display("[TB] FAIL sub_alu: got %0d want 1", if0.AluControlE); else passed++;
    total++; if (if0.RegWriteE !== 1'b1) $display("[TB] FAIL sub_regwrite_e: got %b want 1", if0.RegWriteE); else passed++;
    set_instr(7'b0000000, 3'b000, 7'b0000000);
    tick();
    total++; if ({if0.IllegalE, if0.RegWriteE, if0.RegWriteM} !== 3'b101)
      $display("[TB] FAIL illegal_op: got %b want 101", {if0.IllegalE, if0.RegWriteE, if0.RegWriteM}); else passed++;
    set_instr(7'b0010011, 3'b000, 7'b0000000);
    tick();
    total++; if ({if0.RegWriteW, if0.ResultSrcW} !== 3'b100)
      $display("[TB] FAIL sub_writeback: got %b want 100", {if0.RegWriteW, if0.ResultSrcW}); else passed++;
    set_instr(7'b0110011, 3'b000, 7'b0100000);
    tick();
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    #1;
    total++; if ({if0.RegWriteE, if0.RegWriteM, if0.RegWriteW, if0.AluControlE} !== 7'd0)
      $display("[TB] FAIL midstream_reset: got %b want 0", {if0.RegWriteE, if0.RegWriteM, if0.RegWriteW, if0.AluControlE}); else passed++;
  endtask

  task automatic test_branches();
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    tick();
    zero = 1'b1; #1;
    total++; if ({if0.PCSrcE, if0.TargetSrcE} !== 2'b10)
      $display("[TB] FAIL beq_taken: got %b want 10", {if0.PCSrcE, if0.TargetSrcE}); else passed++;
    zero = 1'b0; #1;
    total++; if (if0.PCSrcE !== 1'b0) $display("[TB] FAIL beq_not_taken: got %b want 0", if0.PCSrcE); else passed++;
    set_instr(7'b1100011, 3'b111, 7'b0000000);
    tick();
    ltu = 1'b1; #1;
    total++; if (if0.PCSrcE !== 1'b0) $display("[TB] FAIL bgeu_ltu: got %b want 0", if0.PCSrcE); else passed++;
    ltu = 1'b0; #1;
    total++; if (if0.PCSrcE !== 1'b1) $display("[TB] FAIL bgeu_geu: got %b want 1", if0.PCSrcE); else passed++;
    set_instr(7'b1100011, 3'b100, 7'b0000000);
    tick();
    lt = 1'b1; #1;
    total++; if ({if0.PCSrcE, if0.AluControlE} !== 5'b10001)
      $display("[TB] FAIL blt_taken: got %b want 10001", {if0.PCSrcE, if0.AluControlE}); else passed++;
    set_instr(7'b1100011, 3'b011, 7'b0000000);
    tick();
    zero = 1'b1; ltu = 1'b1; #1;
    total++; if ({if0.PCSrcE, if0.IllegalE} !== 2'b01)
      $display("[TB] FAIL branch_f3_011: got %b want 01", {if0.PCSrcE, if0.IllegalE}); else passed++;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
  endtask

  task automatic test_jalr();
    set_instr(7'b1100111, 3'b000, 7'b0000000);
    tick();
    total++; if ({if0.PCSrcE, if0.TargetSrcE, if0.AluSrcBE, if0.RegWriteE} !== 4'b1111)
      $display("[TB] FAIL jalr_e: got %b want 1111", {if0.PCSrcE, if0.TargetSrcE, if0.AluSrcBE, if0.RegWriteE}); else passed++;
    set_instr(7'b1100111, 3'b001, 7'b0000000);
    tick();
    total++; if ({if0.IllegalE, if0.PCSrcE, if0.RegWriteE} !== 3'b100)
      $display("[TB] FAIL jalr_bad_f3: got %b want 100", {if0.IllegalE, if0.PCSrcE, if0.RegWriteE}); else passed++;
    set_instr(7'b0010011, 3'b000, 7'b0000000);
    tick();
    total++; if ({if0.ResultSrcW, if0.RegWriteW} !== 3'b101)
      $display("[TB] FAIL jalr_w: got %b want 101", {if0.ResultSrcW, if0.RegWriteW}); else passed++;
  endtask

  task automatic test_flush();
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    tick();
    total++; if (if0.ResultSrcE0 !== 1'b1) $display("[TB] FAIL lw_result_src_e0: got %b want 1", if0.ResultSrcE0); else passed++;
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if ({if0.RegWriteE, if0.AluSrcBE, if0.RegWriteM} !== 3'b001)
      $display("[TB] FAIL flush_bubble: got %b want 001", {if0.RegWriteE, if0.AluSrcBE, if0.RegWriteM}); else passed++;
    set_instr(7'b0010011, 3'b000, 7'b0000000);
    tick();
    total++; if ({if0.MemWriteM, if0.ResultSrcW} !== 3'b001)
      $display("[TB] FAIL flushed_store: got %b want 001", {if0.MemWriteM, if0.ResultSrcW}); else passed++;
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    tick();
    tick();
    total++; if (if0.MemWriteM !== 1'b1) $display("[TB] FAIL store_mem_write: got %b want 1", if0.MemWriteM); else passed++;
  endtask

  task automatic test_mul();
    set_instr(7'b0110011, 3'b000, 7'b0000001);
    tick();
    total++; if ({if0.IllegalE, if0.RegWriteE} !== 2'b10)
      $display("[TB] FAIL mul_disabled: got %b want 10", {if0.IllegalE, if0.RegWriteE}); else passed++;
    total++; if ({if1.AluControlE, if1.IllegalE, if1.RegWriteE} !== 6'b101001)
      $display("[TB] FAIL mul_enabled: got %b want 101001", {if1.AluControlE, if1.IllegalE, if1.RegWriteE}); else passed++;
    set_instr(7'b0010011, 3'b000, 7'b0000000);
    tick();
    tick();
    total++; if ({if0.RegWriteW, if1.RegWriteW} !== 2'b01)
      $display("[TB] FAIL mul_writeback: got %b want 01", {if0.RegWriteW, if1.RegWriteW}); else passed++;
  endtask

  task automatic test_upper();
    set_instr(7'b0110111, 3'b101, 7'b0101010);
    #1;
    total++; if (if0.ImmSrcD !== 3'b100) $display("[TB] FAIL lui_imm_src: got %b want 100", if0.ImmSrcD); else passed++;
    tick();
    set_instr(7'b0010111, 3'b011, 7'b1111111);
    #1;
    total++; if (if0.ImmSrcD !== 3'b100) $display("[TB] FAIL auipc_imm_src: got %b want 100", if0.ImmSrcD); else passed++;
    tick();
    total++; if ({if0.AluSrcAE, if0.AluSrcBE, if0.AluControlE} !== 6'b110000)
      $display("[TB] FAIL auipc_src: got %b want 110000", {if0.AluSrcAE, if0.AluSrcBE, if0.AluControlE}); else passed++;
    set_instr(7'b0010011, 3'b000, 7'b0000000);
    tick();
    total++; if ({if0.ResultSrcW, if0.RegWriteW} !== 3'b111)
      $display("[TB] FAIL lui_writeback: got %b want 111", {if0.ResultSrcW, if0.RegWriteW}); else passed++;
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    ctrl_t cd, ce, cm, cw;
    logic [18:0] expv, actv;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'b0000000;
        1: f7 = 7'b0100000;
        2: f7 = 7'b0000001;
        default: f7 = 7'($urandom);
      endcase
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 49) == 0);
      zero = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        cd = controls_of(mnemonic(op, f3, f7, d == 1));
        ce = controls_of(d == 0 ? e0 : e1);
        cm = controls_of(d == 0 ? m0 : m1);
        cw = controls_of(d == 0 ? w0 : w1);
        expv = {cd.imm, ce.a, ce.b, ce.alu, redirect(d == 0 ? e0 : e1), ce.tgt, cm.mw, cw.rs,
                ce.rw, cm.rw, cw.rw, ce.rs[0], ce.ill};
        if (d == 0)
          actv = {if0.ImmSrcD, if0.AluSrcAE, if0.AluSrcBE, if0.AluControlE, if0.PCSrcE, if0.TargetSrcE,
                  if0.MemWriteM, if0.ResultSrcW, if0.RegWriteE, if0.RegWriteM, if0.RegWriteW,
                  if0.ResultSrcE0, if0.IllegalE};
        else
          actv = {if1.ImmSrcD, if1.AluSrcAE, if1.AluSrcBE, if1.AluControlE, if1.PCSrcE, if1.TargetSrcE,
                  if1.MemWriteM, if1.ResultSrcW, if1.RegWriteE, if1.RegWriteM, if1.RegWriteW,
                  if1.ResultSrcE0, if1.IllegalE};
        total++;
        if (actv !== expv)
          $display("[TB] FAIL random_dut%0d cycle %0d: got %b want %b (E=%s M=%s W=%s)", d, cyc, actv, expv,
                   d == 0 ? e0 : e1, d == 0 ? m0 : m1, d == 0 ? w0 : w1);
        else passed++;
      end
      tick();
    end
    reset = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_branches();
    test_jalr();
    test_flush();
    test_mul();
    test_upper();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
